// File: rtl/avsdpll_pkg.sv
// Shared types and default constants for the avsdpll lock detector.
package avsdpll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_MEASURE,
    ST_LOCKED
  } state_e;

  localparam int unsigned DEF_RATIO      = 8;
  localparam int unsigned DEF_TOL        = 1;
  localparam int unsigned DEF_LOCK_COUNT = 4;
  localparam int unsigned DEF_CNT_W      = 8;

endpackage

// File: rtl/avsdpll_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, plus a one-cycle rising-edge strobe.
module avsdpll_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);

  logic sync1_q;
  logic sync2_q;
  logic sync2_dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync2_dly_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every stage samples its predecessor's pre-edge value.
      sync1_q     <= d_i;
      sync2_q     <= sync1_q;
      sync2_dly_q <= sync2_q;
    end
  end

  assign rise_o = sync2_q & ~sync2_dly_q;

endmodule

// File: rtl/avsdpll_lock_detect.sv
// PLL lock detector: measures CLK cycles per REF period and asserts LOCK after
// LOCK_COUNT consecutive in-tolerance periods; a silent REF saturates and re-arms.
module avsdpll_lock_detect
  import avsdpll_pkg::*;
#(
  parameter int unsigned RATIO      = DEF_RATIO,
  parameter int unsigned TOL        = DEF_TOL,
  parameter int unsigned LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RSTb,
  input  logic             REF,
  input  logic             EN,
  output logic             LOCK,
  output logic [CNT_W-1:0] CYCLES,
  output logic             CYCLES_VALID
);

  localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] SAT = '1;
  localparam logic [CNT_W:0] LO_BOUND = (RATIO > TOL) ? (CNT_W+1)'(RATIO - TOL) : '0;
  localparam logic [CNT_W:0] HI_BOUND = (CNT_W+1)'(RATIO + TOL);

  logic              ref_rise;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;
  logic              valid_q, valid_d;
  logic              lock_q, lock_d;
  logic [CNT_W:0]    meas_ext;
  logic              good_period;

  avsdpll_sync_edge u_ref_sync (
    .clk   (CLK),
    .rst_n (RSTb),
    .d_i   (REF),
    .rise_o(ref_rise)
  );

  // Counter free-runs in every state; only MEASURE/LOCKED act on its value.
  always_comb begin
    if (ref_rise)          cnt_d = CNT_W'(1);
    else if (cnt_q == SAT) cnt_d = cnt_q;
    else                   cnt_d = cnt_q + CNT_W'(1);
  end

  // One extra bit keeps RATIO+TOL from wrapping near SAT.
  assign meas_ext    = {1'b0, cnt_q};
  assign good_period = (meas_ext >= LO_BOUND) && (meas_ext <= HI_BOUND) && (cnt_q != SAT);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d  = state_q;
    good_d   = good_q;
    cycles_d = cycles_q;
    valid_d  = 1'b0;

    if (!EN) begin
      state_d = ST_IDLE;
      good_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_ARM;
        ST_ARM: begin
          if (ref_rise) begin
            state_d = ST_MEASURE;
            good_d  = '0;
          end
        end
        ST_MEASURE, ST_LOCKED: begin
          if (ref_rise) begin
            cycles_d = cnt_q;
            valid_d  = 1'b1;
            if (!good_period) begin
              good_d  = '0;
              state_d = ST_MEASURE;
            end else if (state_q == ST_MEASURE) begin
              if (good_q == GOOD_W'(LOCK_COUNT - 1)) begin
                good_d  = GOOD_W'(LOCK_COUNT);
                state_d = ST_LOCKED;
              end else begin
                good_d = good_q + GOOD_W'(1);
              end
            end
          end else if (cnt_q == SAT) begin
            cycles_d = SAT;
            valid_d  = 1'b1;
            good_d   = '0;
            state_d  = ST_ARM;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    lock_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      good_q   <= '0;
      cycles_q <= '0;
      valid_q  <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      good_q   <= good_d;
      cycles_q <= cycles_d;
      valid_q  <= valid_d;
      lock_q   <= lock_d;
    end
  end

  assign LOCK         = lock_q;
  assign CYCLES       = cycles_q;
  assign CYCLES_VALID = valid_q;

endmodule
